// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the instruction-fetch
// and load/store requesters. One transaction is in flight at a time. Data wins
// ties unless fetch has been passed over MAX_DATA_STREAK times in a row.
//
// Handshake: a requester holds req (and its address/data) high until it sees
// its one-cycle gnt pulse. The arbiter only samples requests in IDLE, so the
// request may change from the cycle after gnt. Completion is a one-cycle
// rvalid (reads) or d_wdone (stores) pulse, with no backpressure.
module mem_port_arbiter #(
  parameter int ADDR_W          = 14,
  parameter int DATA_W          = 32,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wdone,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_INIT   = 3'(RD_LATENCY);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;

  state_t            state, state_d;
  logic [2:0]        lat_cnt, lat_cnt_d;
  logic [3:0]        streak, streak_d;
  logic              owner_data, owner_data_d;
  logic              data_wins;

  logic              if_gnt_d, d_gnt_d, mem_en_d, mem_we_d;
  logic              if_rvalid_d, d_rvalid_d, d_wdone_d, busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    lat_cnt_d    = lat_cnt;
    streak_d     = streak;
    owner_data_d = owner_data;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    d_wdone_d    = 1'b0;
    if_rdata_d   = if_rdata;
    d_rdata_d    = d_rdata;
    data_wins    = d_req && (!if_req || (streak < STREAK_MAX));

    case (state)
      IDLE: begin
        if (data_wins) begin
          d_gnt_d      = 1'b1;
          mem_en_d     = 1'b1;
          mem_addr_d   = d_addr;
          owner_data_d = 1'b1;
          // Only grants that actually make fetch wait count toward the streak.
          if (if_req && (streak < STREAK_MAX)) streak_d = streak + 4'd1;
          if (d_we) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = d_wdata;
            state_d     = WR_DONE;
          end else begin
            lat_cnt_d = LAT_INIT;
            state_d   = RD_WAIT;
          end
        end else if (if_req) begin
          if_gnt_d     = 1'b1;
          mem_en_d     = 1'b1;
          mem_addr_d   = if_addr;
          owner_data_d = 1'b0;
          streak_d     = 4'd0;
          lat_cnt_d    = LAT_INIT;
          state_d      = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Counter reaches zero in the cycle the RAM presents the read word.
        if (lat_cnt == 3'd0) begin
          state_d = IDLE;
          if (owner_data) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt - 3'd1;
        end
      end
      WR_DONE: begin
        d_wdone_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      streak     <= 4'd0;
      owner_data <= 1'b0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      d_wdone    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      streak     <= streak_d;
      owner_data <= owner_data_d;
      if_gnt     <= if_gnt_d;
      d_gnt      <= d_gnt_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_rvalid  <= if_rvalid_d;
      d_rvalid   <= d_rvalid_d;
      d_wdone    <= d_wdone_d;
      if_rdata   <= if_rdata_d;
      d_rdata    <= d_rdata_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model with configurable latency, two
// requester drivers, a transaction-level arbitration model that predicts every
// grant and completion, and a monitor that pops and compares those predictions.
module tb_mem_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int MAXS = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          is_d;
    logic          is_wr;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, d_wdone;
  logic          mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wdone(d_wdone),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] pipe [LAT];
  assign mem_rdata = pipe[LAT-1];

  // Garbage fills the pipeline when no read is issued so off-by-one capture shows.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  // ---------------- scoreboard state ----------------
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   streak = 0;
  int   next_free = 0;
  int   last_sample = -1;
  logic [DW-1:0] exp_if_rdata = '0, exp_d_rdata = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // ---------------- requester drivers ----------------
  logic          f_act = 1'b0, f_granted = 1'b0;
  int            f_gs = 0;
  logic [AW-1:0] f_a = '0;
  logic          dr_act = 1'b0, dr_granted = 1'b0, dr_w = 1'b0;
  int            dr_gs = 0;
  logic [AW-1:0] dr_a = '0;
  logic [DW-1:0] dr_wd = '0;
  logic [AW-1:0] f_force_q[$];
  logic [AW+DW:0] d_force_q[$];   // {we, addr, wdata}
  int            f_rate = 0, d_rate = 0;

  // Called at the negedge of cycle c: retire granted requests, start new ones.
  task automatic drive_step(input int c);
    logic [AW+DW:0] fd;
    if (f_act && f_granted && c >= f_gs + 2) f_act = 1'b0;
    if (dr_act && dr_granted && c >= dr_gs + 2) dr_act = 1'b0;
    if (!f_act) begin
      if (f_force_q.size() > 0) begin
        f_act = 1'b1; f_granted = 1'b0; f_a = f_force_q.pop_front();
      end else if ($urandom_range(0, 99) < f_rate) begin
        f_act = 1'b1; f_granted = 1'b0; f_a = AW'($urandom_range(0, 31));
      end
    end
    if (!dr_act) begin
      if (d_force_q.size() > 0) begin
        fd = d_force_q.pop_front();
        dr_act = 1'b1; dr_granted = 1'b0;
        dr_w = fd[AW+DW]; dr_a = fd[AW+DW-1:DW]; dr_wd = fd[DW-1:0];
      end else if ($urandom_range(0, 99) < d_rate) begin
        dr_act = 1'b1; dr_granted = 1'b0;
        dr_w = 1'($urandom_range(0, 1)); dr_a = AW'($urandom_range(0, 31)); dr_wd = $urandom;
      end
    end
    if_req  = f_act;
    if_addr = f_act ? f_a : AW'($urandom);
    d_req   = dr_act;
    d_we    = dr_act ? dr_w : 1'($urandom_range(0, 1));
    d_addr  = dr_act ? dr_a : AW'($urandom);
    d_wdata = dr_act ? dr_wd : $urandom;
  endtask

  // ---------------- reference model ----------------
  // Transaction level: the port is free again at next_free; a read occupies it
  // for LAT+2 cycles from the sampling cycle, a store for 2.
  task automatic model_step(input int c);
    logic dw;
    if (c >= next_free && (if_req || d_req)) begin
      dw = d_req && (!if_req || streak < MAXS);
      last_sample = c;
      if (dw) begin
        gnt_q.push_back('{cyc: 32'(c+1), is_d: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata});
        if (d_we) begin
          ref_mem[d_addr] = d_wdata;
          rsp_q.push_back('{cyc: 32'(c+2), is_d: 1'b1, is_wr: 1'b1, data: '0});
          next_free = c + 2;
        end else begin
          rsp_q.push_back('{cyc: 32'(c+2+LAT), is_d: 1'b1, is_wr: 1'b0, data: ref_mem[d_addr]});
          next_free = c + 2 + LAT;
        end
        if (if_req) streak = (streak + 1 > MAXS) ? MAXS : streak + 1;
        dr_granted = 1'b1; dr_gs = c;
      end else begin
        gnt_q.push_back('{cyc: 32'(c+1), is_d: 1'b0, we: 1'b0, addr: if_addr, wdata: '0});
        rsp_q.push_back('{cyc: 32'(c+2+LAT), is_d: 1'b0, is_wr: 1'b0, data: ref_mem[if_addr]});
        next_free = c + 2 + LAT;
        streak = 0;
        f_granted = 1'b1; f_gs = c;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive_step(cyc);
      model_step(cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_step();
    int   c;
    gnt_t g;
    rsp_t r;
    c = cyc;
    chk("busy", busy, (c > last_sample) && (c < next_free));
    chk("we_without_en", mem_we & ~mem_en, 1'b0);
    if (if_gnt || d_gnt || mem_en) begin
      if (gnt_q.size() == 0 || gnt_q[0].cyc != 32'(c)) begin
        chk("grant_unexpected", {if_gnt, d_gnt, mem_en}, 3'b000);
      end else begin
        g = gnt_q.pop_front();
        chk("grant_owner", {if_gnt, d_gnt, mem_en}, {~g.is_d, g.is_d, 1'b1});
        chk("grant_we", mem_we, g.we);
        chk("grant_addr", mem_addr, g.addr);
        if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
      end
    end else if (gnt_q.size() > 0 && gnt_q[0].cyc <= 32'(c)) begin
      g = gnt_q.pop_front();
      chk("grant_missing", {if_gnt, d_gnt, mem_en}, {~g.is_d, g.is_d, 1'b1});
    end
    if (if_rvalid || d_rvalid || d_wdone) begin
      if (rsp_q.size() == 0 || rsp_q[0].cyc != 32'(c)) begin
        chk("resp_unexpected", {if_rvalid, d_rvalid, d_wdone}, 3'b000);
      end else begin
        r = rsp_q.pop_front();
        chk("resp_kind", {if_rvalid, d_rvalid, d_wdone},
            r.is_d ? (r.is_wr ? 3'b001 : 3'b010) : 3'b100);
        if (!r.is_wr) begin
          if (r.is_d) exp_d_rdata = r.data;
          else exp_if_rdata = r.data;
        end
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= 32'(c)) begin
      r = rsp_q.pop_front();
      chk("resp_missing", {if_rvalid, d_rvalid, d_wdone},
          r.is_d ? (r.is_wr ? 3'b001 : 3'b010) : 3'b100);
    end
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) mon_step();
    end
  end

  function automatic logic [127:0] all_outs();
    return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_wdone,
            mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[14'h010] = 32'h8C08_0004;
    ref_mem[14'h010] = 32'h8C08_0004;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch from 0x010.
    f_force_q.push_back(14'h010);
    run_cycles(12);
    // Store 0xDEADBEEF to 0x200, then load it back as soon as allowed.
    d_force_q.push_back({1'b1, 14'h200, 32'hDEAD_BEEF});
    d_force_q.push_back({1'b0, 14'h200, 32'h0});
    run_cycles(16);
    // Collision: both requesters rise together.
    f_force_q.push_back(14'h005);
    d_force_q.push_back({1'b0, 14'h200, 32'h0});
    run_cycles(20);
    // Both requesters saturated: exercises the streak limiter.
    f_rate = 100; d_rate = 100;
    run_cycles(200);
    // Mixed random traffic.
    f_rate = 40; d_rate = 40;
    run_cycles(500);

    // Reset in the third cycle of an isolated fetch read.
    f_rate = 0; d_rate = 0;
    run_cycles(20);
    f_force_q.push_back(14'h011);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (f_act && f_granted && cyc == f_gs + 2) found = 1'b1;
      else begin
        drive_step(cyc);
        model_step(cyc);
      end
    end
    chk("reset_setup_reached", found, 1'b1);
    rst_n = 1'b0;
    gnt_q.delete();
    rsp_q.delete();
    streak = 0; next_free = 0; last_sample = -1;
    exp_if_rdata = '0; exp_d_rdata = '0;
    f_act = 1'b0; dr_act = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    #1 chk("midread_reset_outputs", all_outs(), 128'd0);
    repeat (3) @(negedge clk);
    chk("reset_hold_outputs", all_outs(), 128'd0);
    rst_n = 1'b1;

    // Traffic after reset, starting from a data request with fetch waiting.
    d_force_q.push_back({1'b0, 14'h200, 32'h0});
    f_force_q.push_back(14'h010);
    f_rate = 40; d_rate = 60;
    run_cycles(300);

    // Drain with a bounded budget.
    f_rate = 0; d_rate = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      drive_step(cyc);
      model_step(cyc);
      if (gnt_q.size() == 0 && rsp_q.size() == 0 && !f_act && !dr_act && cyc >= next_free) break;
    end
    @(negedge clk);
    chk("drain_grants", 128'(gnt_q.size()), 128'd0);
    chk("drain_responses", 128'(rsp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
